xalu_nibble_seq: RTL
====================

XALU_NIBBLE_SEQ -- requirements
Module: xalu_nibble_seq

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: rst  input  1  reset, asynchronous, active-high.
REQ-003: start  input  1  request a 16-bit operation; sampled only in IDLE.
REQ-004: op  input  3  function code, passed unchanged to alu_f: 0 ADD, 1 AND, 2 OR, 3 XOR, 4 PASSA, 5 PASSB, 6 SHR, 7 SHL.
REQ-005: opa, opb  input  16 each  operands A and B.
REQ-006: cin  input  1  initial carry: carry-in for ADD/SHL, shift-in bit for SHR.
REQ-007: inv  input  1  complement-output request, latched and driven on alu_com.
REQ-008: alu_a, alu_b  output  4 each  nibble operands to the 4-bit ALU slice.
REQ-009: alu_f  output  3  function code to the slice.
REQ-010: alu_cir, alu_cil, alu_com  output  1 each  slice right carry-in, left carry-in and complement mode.
REQ-011: alu_d  input  4  slice data result.
REQ-012: alu_col, alu_cor  input  1 each  slice left and right carry-out.
REQ-013: busy  output  1  high while in RUN.
REQ-014: done  output  1  one-cycle completion pulse.
REQ-015: result  output  16  registered result.
REQ-016: cout  output  1  final carry/shift-out.
REQ-017: zero  output  1  high when result == 16'h0000.

Function
REQ-018: FSM has three states, IDLE, RUN and DONE, plus a 2-bit nibble index idx.
REQ-019: In IDLE with start=1 at an edge, the block latches op, opa, opb, inv, loads carry reg from cin, clears idx to 0 and enters RUN.
REQ-020: In IDLE, start=0 holds state; start is ignored in RUN and DONE (no queuing).
REQ-021: In RUN, slice inputs are driven combinationally from latched registers and idx; the slice path is fully combinational.
REQ-022: Nibble order is LSB-first, nibble n = idx, for ops 0-5 and 7; MSB-first, nibble n = 3-idx, for SHR (6).
REQ-023: alu_a = A[4n+3:4n]; alu_b = B[4n+3:4n]; alu_f = latched op; alu_com = latched inv.
REQ-024: For ADD/SHL, alu_cir = carry reg and alu_cil = 0; for SHR, alu_cil = carry reg and alu_cir = 0; for other ops both are 0.
REQ-025: Each RUN edge writes alu_d into result[4n+3:4n].
REQ-026: On the same edge, carry reg <= alu_col for ADD/SHL, alu_cor for SHR, and 0 for ops 1-5.
REQ-027: On each RUN edge, idx increments; the edge with idx=3 moves the FSM to DONE.
REQ-028: Latency: accept edge E0; nibbles are captured on E1-E4; done=1 for exactly the cycle after E4; the next edge returns to IDLE.
REQ-029: A start accepted in the IDLE cycle right after DONE begins a new operation; back-to-back throughput is one operation per 6 cycles.
REQ-030: cout = carry reg after the final nibble; it holds until the next accept.
REQ-031: result, cout and zero hold their values in IDLE until the next accept.
REQ-032: zero is decoded from registered result and is valid whenever done=1.
REQ-033: In IDLE and DONE, alu_a, alu_b, alu_f, alu_cir, alu_cil and alu_com are 0.
REQ-034: Operand inputs may change freely after the accept edge without affecting the operation in progress.

Reset
REQ-035: While rst=1, the block is forced to IDLE, idx=0, carry reg=0, result=0, cout=0, busy=0 and done=0; all alu_* outputs are 0 and zero=1.
REQ-036: Asserting rst mid-RUN or in DONE aborts the operation immediately; no done pulse follows, and the first accept after deassertion behaves normally.

Verification
REQ-037: ADD, opa=16'hFFFF, opb=16'h0001, cin=0 -> done 4 clocks after accept, result=16'h0000, cout=1, zero=1; busy high for exactly 4 cycles.
REQ-038: SHL, opa=16'h8421, cin=1 -> result=16'h0843, cout=1; alu_a sequence 1,2,4,8.
REQ-039: SHR, opa=16'h8421, cin=0 -> result=16'h4210, cout=1; alu_a sequence 8,4,2,1.
REQ-040: XOR, opa=opb=16'h1234 -> result=16'h0000, zero=1, cout=0. Repeat with inv=1 -> result=16'hFFFF, zero=0.
REQ-041: Start held high continuously with ADD, opa=16'h0001, opb=16'h0001 -> accepts occur exactly 6 cycles apart, each result=16'h0002; start pulses during RUN are ignored.
REQ-042: rst pulsed on the edge after E2 of an ADD -> busy=0, done never pulses, result=0; a following ADD, opa=16'h000F, opb=16'h0001 -> result=16'h0010, cout=0.

Source files
------------

// File: rtl/xalu_nibble_seq.sv
// -----------------------------------------------------------------------------
// xalu_nibble_seq
//
// Purpose:
//   Sequences a 16-bit operation through an external, purely combinational
//   4-bit ALU slice. The slice is used once per nibble over four RUN cycles.
//   The carry or shift bit passes between nibbles through an internal
//   register. LSB-first order is used for every op except SHR, which runs
//   MSB-first so that the shift-in bit enters at the top of the word.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start                     request an operation (sampled only in IDLE)
//   op[2:0]                   function code forwarded to the slice
//   opa[15:0], opb[15:0]      operands A and B
//   cin                       initial carry / shift-in bit
//   inv                       complement-output request (drives alu_com)
//   alu_a, alu_b, alu_f       nibble operands and function to the slice
//   alu_cir, alu_cil, alu_com slice right/left carry-in, complement mode
//   alu_d, alu_col, alu_cor   slice result and left/right carry-out
//   busy                      high while in RUN
//   done                      one-cycle completion pulse
//   result[15:0]              registered result
//   cout                      final carry / shift-out
//   zero                      result == 0
// -----------------------------------------------------------------------------
module xalu_nibble_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [15:0] opa,
    input  logic [15:0] opb,
    input  logic        cin,
    input  logic        inv,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic [2:0]  alu_f,
    output logic        alu_cir,
    output logic        alu_cil,
    output logic        alu_com,
    input  logic [3:0]  alu_d,
    input  logic        alu_col,
    input  logic        alu_cor,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        cout,
    output logic        zero
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SHR = 3'd6;
    localparam logic [2:0] OP_SHL = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [1:0]  r_idx;
    logic [2:0]  r_op;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic        r_inv;
    logic        r_carry;
    logic [15:0] r_result;
    logic        r_busy;
    logic        r_done;

    logic        w_run;
    logic        w_is_shr;
    logic        w_is_left_carry;   // ADD/SHL chain carries leftwards
    logic [1:0]  w_nib;
    logic [3:0]  w_bit_ofs;
    logic        w_carry_next;

    assign w_run           = (r_state == S_RUN);
    assign w_is_shr        = (r_op == OP_SHR);
    assign w_is_left_carry = (r_op == OP_ADD) || (r_op == OP_SHL);

    // SHR walks from the top nibble down; everything else walks upward.
    assign w_nib     = w_is_shr ? (2'd3 - r_idx) : r_idx;
    assign w_bit_ofs = {w_nib, 2'b00};

    // Slice drive: all zero outside RUN so the slice sees a quiet bus.
    assign alu_a   = w_run ? r_a[w_bit_ofs +: 4] : 4'h0;
    assign alu_b   = w_run ? r_b[w_bit_ofs +: 4] : 4'h0;
    assign alu_f   = w_run ? r_op : 3'd0;
    assign alu_com = w_run & r_inv;
    assign alu_cir = w_run & w_is_left_carry & r_carry;
    assign alu_cil = w_run & w_is_shr & r_carry;

    // Carry chained to the next nibble; logic ops and pass-throughs break it.
    always_comb begin
        w_carry_next = 1'b0;
        if (w_is_left_carry) begin
            w_carry_next = alu_col;
        end else if (w_is_shr) begin
            w_carry_next = alu_cor;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_idx    <= 2'd0;
            r_op     <= 3'd0;
            r_a      <= 16'h0000;
            r_b      <= 16'h0000;
            r_inv    <= 1'b0;
            r_carry  <= 1'b0;
            r_result <= 16'h0000;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_a     <= opa;
                        r_b     <= opb;
                        r_inv   <= inv;
                        r_carry <= cin;
                        r_idx   <= 2'd0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_result[w_bit_ofs +: 4] <= alu_d;
                    r_carry <= w_carry_next;
                    r_idx   <= r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign cout   = r_carry;
    assign zero   = (r_result == 16'h0000);

endmodule
